// File: rtl/avl_mem_model_pkg.sv
// Shared types and helpers for the Avalon burst memory model: FSM states,
// LFSR polynomial and memory geometry functions.
package avl_mem_model_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_ISSUE
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic int word_count(input int size_kb, input int data_width);
    return (size_kb * 1024 * 8) / data_width;
  endfunction

  function automatic int word_aw(input int size_kb, input int data_width);
    int words;
    words = word_count(size_kb, data_width);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Right-shifting Galois form: the polynomial is folded in when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/avl_resp_fifo.sv
// Synchronous FIFO for read responses; push and pop may happen in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module avl_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  assign pop_data = storage[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/avl_mem_burst_model.sv
// Cycle-deterministic Avalon-style burst memory slave with fixed read latency,
// credit-limited in-order response queue and LFSR-driven backpressure.
module avl_mem_burst_model
  import avl_mem_model_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          SIZE_KB      = 32,
  parameter int          BURST_W      = 4,
  parameter int          READ_LATENCY = 2,
  parameter int          RESP_DEPTH   = 8,
  parameter int          STALL_EN     = 1,
  parameter int          STALL_BITS   = 2,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    rest,
  input  logic [ADDR_WIDTH-1:0]   avl_address,
  input  logic [DATA_WIDTH/8-1:0] avl_byte_en,
  input  logic [DATA_WIDTH-1:0]   avl_write_data,
  input  logic                    avl_write,
  input  logic                    avl_read,
  input  logic                    avl_begin_burst_transfer,
  input  logic [BURST_W-1:0]      avl_burst_count,
  output logic                    avl_request_ready,
  output logic [DATA_WIDTH-1:0]   avl_read_data,
  output logic                    avl_read_data_valid,
  input  logic                    avl_resp_ready,
  output logic                    protocol_err
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_AW = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int WORDS   = word_count(SIZE_KB, DATA_WIDTH);
  localparam int WORD_AW = word_aw(SIZE_KB, DATA_WIDTH);
  localparam int CNT_W   = $clog2(RESP_DEPTH) + 1;
  localparam int SUM_W   = ((CNT_W > BURST_W) ? CNT_W : BURST_W) + 2;

  state_t                state;
  state_t                next_state;
  logic [31:0]           lfsr;
  logic                  req_mask;
  logic                  rsp_mask;
  logic                  req_ok;
  logic [WORD_AW-1:0]    addr_idx;
  logic [WORD_AW-1:0]    idx;
  logic [BURST_W-1:0]    burst_len;
  logic [BURST_W-1:0]    remaining;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic [SUM_W-1:0]      credit_sum;
  logic                  credit_ok;
  logic                  request_ready;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  wr_beat;
  logic                  issue;
  logic                  err_set;
  logic                  err;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat [READ_LATENCY];
  logic                  unused_addr;

  function automatic logic [WORD_AW-1:0] next_word(input logic [WORD_AW-1:0] i);
    return (i == WORD_AW'(WORDS - 1)) ? '0 : i + WORD_AW'(1);
  endfunction

  assign unused_addr = ^avl_address;
  assign addr_idx    = avl_address[BYTE_AW +: WORD_AW];
  assign burst_len   = (avl_burst_count == '0) ? BURST_W'(1) : avl_burst_count;

  assign req_mask = (STALL_EN == 0) || (lfsr[STALL_BITS-1:0] == '0);
  assign rsp_mask = (STALL_EN == 0) || (lfsr[8 +: STALL_BITS] == '0);
  assign req_ok   = req_mask && !rest;

  // inflight counts beats accepted but not yet in the FIFO, so the sum is all outstanding beats.
  assign credit_sum = SUM_W'(fifo_count) + SUM_W'(inflight) + SUM_W'(burst_len);
  assign credit_ok  = (credit_sum <= SUM_W'(RESP_DEPTH));

  always_ff @(posedge clk) begin
    if (rest) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    request_ready = 1'b0;
    rd_accept     = 1'b0;
    wr_accept     = 1'b0;
    wr_beat       = 1'b0;
    issue         = 1'b0;
    err_set       = 1'b0;
    case (state)
      IDLE: begin
        request_ready = req_ok && (avl_read ? credit_ok : 1'b1);
        err_set       = avl_read && avl_write;
        if (request_ready && avl_read) begin
          rd_accept  = 1'b1;
          next_state = RD_ISSUE;
        end else if (request_ready && avl_write) begin
          wr_accept = 1'b1;
          if (burst_len != BURST_W'(1)) next_state = WR_BURST;
        end
      end
      WR_BURST: begin
        request_ready = req_ok;
        err_set       = avl_read || (avl_write && avl_begin_burst_transfer);
        if (req_ok && avl_write && !avl_read && !avl_begin_burst_transfer) begin
          wr_beat = 1'b1;
          if (remaining == BURST_W'(1)) next_state = IDLE;
        end
      end
      RD_ISSUE: begin
        issue = !rest;
        if (remaining == BURST_W'(1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      idx       <= '0;
      remaining <= '0;
      inflight  <= '0;
      err       <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (err_set) err <= 1'b1;
      if (rd_accept) begin
        idx       <= addr_idx;
        remaining <= burst_len;
      end else if (wr_accept) begin
        idx       <= next_word(addr_idx);
        remaining <= burst_len - BURST_W'(1);
      end else if (wr_beat || issue) begin
        idx       <= next_word(idx);
        remaining <= remaining - BURST_W'(1);
      end
      inflight <= inflight + (rd_accept ? CNT_W'(burst_len) : '0) - (push ? CNT_W'(1) : '0);
    end
  end

  // Memory has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_accept || wr_beat) begin
      for (int b = 0; b < BYTES; b++) begin
        if (avl_byte_en[b]) mem[wr_accept ? addr_idx : idx][8*b +: 8] <= avl_write_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_dat[0] <= mem[idx];
    for (int i = 1; i < READ_LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  assign push = pipe_vld[READ_LATENCY-1];

  avl_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rest      (rest),
    .push      (push),
    .push_data (pipe_dat[READ_LATENCY-1]),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign avl_read_data_valid = !fifo_empty && rsp_mask;
  assign avl_read_data       = fifo_empty ? '0 : head;
  assign pop                 = avl_read_data_valid && avl_resp_ready;
  assign avl_request_ready   = request_ready;
  assign protocol_err        = err;

endmodule

// File: tb/tb_avl_mem_burst_model.sv
// Directed bench for avl_mem_burst_model with stalls off, 1 KiB array,
// READ_LATENCY=2 and an 8-entry response queue.
module tb_avl_mem_burst_model;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic [31:0] avl_address = '0;
  logic [3:0]  avl_byte_en = '0;
  logic [31:0] avl_write_data = '0;
  logic        avl_write = 1'b0;
  logic        avl_read = 1'b0;
  logic        avl_begin_burst_transfer = 1'b0;
  logic [2:0]  avl_burst_count = '0;
  logic        avl_request_ready;
  logic [31:0] avl_read_data;
  logic        avl_read_data_valid;
  logic        avl_resp_ready = 1'b1;
  logic        protocol_err;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] got[$];
  int          gotLat[$];
  logic [31:0] drainExp [8];

  avl_mem_burst_model #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .SIZE_KB      (1),
    .BURST_W      (3),
    .READ_LATENCY (2),
    .RESP_DEPTH   (8),
    .STALL_EN     (0),
    .STALL_BITS   (2),
    .LFSR_SEED    (32'hACE1_2468)
  ) dut (
    .clk                      (clk),
    .rest                     (rest),
    .avl_address              (avl_address),
    .avl_byte_en              (avl_byte_en),
    .avl_write_data           (avl_write_data),
    .avl_write                (avl_write),
    .avl_read                 (avl_read),
    .avl_begin_burst_transfer (avl_begin_burst_transfer),
    .avl_burst_count          (avl_burst_count),
    .avl_request_ready        (avl_request_ready),
    .avl_read_data            (avl_read_data),
    .avl_read_data_valid      (avl_read_data_valid),
    .avl_resp_ready           (avl_resp_ready),
    .protocol_err             (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the request until ready, completes the handshake
  // on the next posedge and returns at the following negedge with the bus idle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be,
                               input logic [2:0] cnt, input logic bb);
    int w;
    avl_read = rd;
    avl_write = wr;
    avl_address = addr;
    avl_write_data = data;
    avl_byte_en = be;
    avl_burst_count = cnt;
    avl_begin_burst_transfer = bb;
    w = 0;
    while (!avl_request_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput("req_ready", {31'b0, avl_request_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    avl_read = 1'b0;
    avl_write = 1'b0;
    avl_begin_burst_transfer = 1'b0;
    avl_byte_en = '0;
  endtask

  // Cycle 1 is the negedge right after the handshake edge.
  task automatic collectBeats(input int cnt);
    int n;
    got.delete();
    gotLat.delete();
    n = 1;
    while (got.size() < cnt && n < 60) begin
      if (avl_read_data_valid && avl_resp_ready) begin
        got.push_back(avl_read_data);
        gotLat.push_back(n);
      end
      @(negedge clk);
      n++;
    end
    checkOutput("beat_count", got.size(), cnt);
  endtask

  task automatic readWords(input logic [31:0] addr, input logic [2:0] cnt);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0, cnt, 1'b1);
    collectBeats(int'(cnt));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'b0, avl_request_ready}, 32'd0);
    checkOutput("rst_valid", {31'b0, avl_read_data_valid}, 32'd0);
    checkOutput("rst_data", avl_read_data, 32'd0);
    checkOutput("rst_err", {31'b0, protocol_err}, 32'd0);
    rest = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd1, 1'b1);
    readWords(32'h10, 3'd1);
    checkOutput("single_latency", gotLat[0], 32'd4);
    checkOutput("single_data", got[0], 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h00000055, 4'b0001, 3'd1, 1'b1);
    readWords(32'h20, 3'd1);
    checkOutput("byte_en_merge", got[0], 32'hFFFFFF55);

    applyStimulus(1'b0, 1'b1, 32'h40, 32'd1, 4'hF, 3'd4, 1'b1);
    for (int i = 2; i <= 4; i++) applyStimulus(1'b0, 1'b1, 32'h0, i, 4'hF, 3'd0, 1'b0);
    readWords(32'h40, 3'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("burst_beat%0d", i), got[i], i + 1);
    checkOutput("burst_back_to_back", gotLat[3] - gotLat[0], 32'd3);

    avl_resp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'd4, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'd4, 1'b1);
    avl_read = 1'b1;
    avl_address = 32'h20;
    avl_burst_count = 3'd1;
    avl_begin_burst_transfer = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("credit_block", {31'b0, avl_request_ready}, 32'd0);
    checkOutput("full_valid", {31'b0, avl_read_data_valid}, 32'd1);
    checkOutput("full_head", avl_read_data, 32'd1);
    avl_resp_ready = 1'b1;
    @(negedge clk);
    avl_resp_ready = 1'b0;
    checkOutput("credit_release", {31'b0, avl_request_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    avl_read = 1'b0;
    avl_begin_burst_transfer = 1'b0;
    avl_resp_ready = 1'b1;
    drainExp = '{32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFFFF55};
    collectBeats(8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("drain_beat%0d", i), got[i], drainExp[i]);

    applyStimulus(1'b0, 1'b1, 32'h3FC, 32'hAAAA0001, 4'hF, 3'd2, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h123, 32'hAAAA0002, 4'hF, 3'd0, 1'b0);
    readWords(32'h0, 3'd1);
    checkOutput("wrap_word0", got[0], 32'hAAAA0002);
    readWords(32'h3FC, 3'd2);
    checkOutput("wrap_rd_last", got[0], 32'hAAAA0001);
    checkOutput("wrap_rd_first", got[1], 32'hAAAA0002);

    checkOutput("err_clear_before", {31'b0, protocol_err}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, 3'd1, 1'b1);
    collectBeats(1);
    checkOutput("rw_read_wins", got[0], 32'hDEADBEEF);
    checkOutput("err_set", {31'b0, protocol_err}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", {31'b0, protocol_err}, 32'd1);
    rest = 1'b1;
    @(negedge clk);
    checkOutput("rst2_err", {31'b0, protocol_err}, 32'd0);
    checkOutput("rst2_valid", {31'b0, avl_read_data_valid}, 32'd0);
    checkOutput("rst2_ready", {31'b0, avl_request_ready}, 32'd0);
    rest = 1'b0;
    @(negedge clk);
    readWords(32'h10, 3'd1);
    checkOutput("mem_kept_10", got[0], 32'hDEADBEEF);
    readWords(32'h20, 3'd1);
    checkOutput("mem_kept_20", got[0], 32'hFFFFFF55);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
